// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: round-robin arbiter in front of a shared byte-lane RAM with     |
// | a fixed-latency tagged read pipeline.           Rev 1.0                      |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]        addr_i,
  input  logic [NUM_PORTS-1:0]               wr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]        wr_data_i,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0]    byte_en_i,
  output logic [NUM_PORTS-1:0]               gnt_o,
  output logic [NUM_PORTS-1:0]               rvalid_o,
  output logic [NUM_PORTS*DATA_W-1:0]        rd_data_o,
  output logic [NUM_PORTS-1:0]               err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PID_W-1:0]  r_rr_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_vld [RD_LAT];
  logic [PID_W-1:0]  r_pid [RD_LAT];
  logic [DATA_W-1:0] r_dat [RD_LAT];

  logic              w_found;
  logic [PID_W-1:0]  w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_widx;
  logic [IDX_W-1:0]  w_aidx;
  logic              w_oor;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_be;
  logic              w_wen;
  logic              w_ren;
  logic [DATA_W-1:0] w_rdat;

  // Round-robin search: first requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      automatic int j = (int'(r_rr_ptr) + i) % NUM_PORTS;
      if (!w_found && req_i[j]) begin
        w_found = 1'b1;
        w_sel   = PID_W'(j);
      end
    end
  end

  always_comb begin
    w_addr  = addr_i[w_sel*ADDR_W +: ADDR_W];
    w_wdata = wr_data_i[w_sel*DATA_W +: DATA_W];
    w_be    = byte_en_i[w_sel*BE_W +: BE_W];
    w_widx  = w_addr >> OFF_W;
    w_aidx  = w_widx[IDX_W-1:0];
    w_oor   = |(w_widx >> IDX_W);
    w_wen   = w_found && !reset && wr_i[w_sel] && !w_oor;
    w_ren   = w_found && !reset && !wr_i[w_sel];
    w_rdat  = w_oor ? '0 : r_mem[w_aidx];
  end

  always_comb begin
    gnt_o = '0;
    err_o = '0;
    if (w_found && !reset) begin
      gnt_o[w_sel] = 1'b1;
      err_o[w_sel] = w_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= (w_sel == PID_W'(NUM_PORTS - 1)) ? '0 : w_sel + 1'b1;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_be[b]) r_mem[w_aidx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) r_vld[i] <= 1'b0;
    end else begin
      r_vld[0] <= w_ren;
      r_pid[0] <= w_sel;
      r_dat[0] <= w_rdat;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_pid[i] <= r_pid[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  always_comb begin
    rvalid_o  = '0;
    rd_data_o = '0;
    if (!reset && r_vld[RD_LAT-1]) begin
      rvalid_o[r_pid[RD_LAT-1]]                  = 1'b1;
      rd_data_o[r_pid[RD_LAT-1]*DATA_W +: DATA_W] = r_dat[RD_LAT-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter: vector table on the default build plus RD_LAT=3/2 sequences. |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, wr, gnt, rv, err;
  logic [63:0] addr, wdata, rdata;
  logic [7:0]  be;

  logic        s_rst;
  logic [1:0]  s_req, s_wr;
  logic [63:0] s_addr, s_wdata;
  logic [7:0]  s_be;
  logic [1:0]  l3_gnt, l3_rv, l3_err, l2_gnt, l2_rv, l2_err;
  logic [63:0] l3_rd, l2_rd;

  mem_arbiter u_dut (
    .clk(clk), .reset(rst), .req_i(req), .addr_i(addr), .wr_i(wr),
    .wr_data_i(wdata), .byte_en_i(be), .gnt_o(gnt), .rvalid_o(rv),
    .rd_data_o(rdata), .err_o(err)
  );

  mem_arbiter #(.DEPTH(16), .RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(s_rst), .req_i(s_req), .addr_i(s_addr), .wr_i(s_wr),
    .wr_data_i(s_wdata), .byte_en_i(s_be), .gnt_o(l3_gnt), .rvalid_o(l3_rv),
    .rd_data_o(l3_rd), .err_o(l3_err)
  );

  mem_arbiter #(.DEPTH(16), .RD_LAT(2)) u_lat2 (
    .clk(clk), .reset(s_rst), .req_i(s_req), .addr_i(s_addr), .wr_i(s_wr),
    .wr_data_i(s_wdata), .byte_en_i(s_be), .gnt_o(l2_gnt), .rvalid_o(l2_rv),
    .rd_data_o(l2_rd), .err_o(l2_err)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req, wr;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  be0, be1;
    logic [1:0]  gnt, err, rv;
    logic [31:0] r0, r1;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    //          rst   req    wr     a0        a1        d0            d1            be0   be1    gnt    err    rv     r0            r1
    tv[0]  = '{1'b1, 2'b11, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[1]  = '{1'b1, 2'b11, 2'b11, 32'h1000, 32'h10,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 4'hF, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[2]  = '{1'b0, 2'b10, 2'b10, 32'h0,    32'h10,   32'h0,        32'hDEADBEEF, 4'h0, 4'hF, 2'b10, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[3]  = '{1'b0, 2'b10, 2'b00, 32'h0,    32'h10,   32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[4]  = '{1'b0, 2'b10, 2'b10, 32'h0,    32'h11,   32'h0,        32'h000000AA, 4'h0, 4'h1, 2'b10, 2'b00, 2'b10, 32'h0,        32'hDEADBEEF};
    tv[5]  = '{1'b0, 2'b10, 2'b00, 32'h0,    32'h10,   32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[6]  = '{1'b0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b10, 32'h0,        32'hDEADBEAA};
    tv[7]  = '{1'b0, 2'b11, 2'b00, 32'h10,   32'h10,   32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[8]  = '{1'b0, 2'b11, 2'b00, 32'h10,   32'h10,   32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b00, 2'b01, 32'hDEADBEAA, 32'h0};
    tv[9]  = '{1'b0, 2'b11, 2'b11, 32'h20,   32'h24,   32'h11223344, 32'h55667788, 4'hF, 4'hF, 2'b01, 2'b00, 2'b10, 32'h0,        32'hDEADBEAA};
    tv[10] = '{1'b0, 2'b11, 2'b11, 32'h20,   32'h24,   32'h11223344, 32'h55667788, 4'hF, 4'hF, 2'b10, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[11] = '{1'b0, 2'b11, 2'b00, 32'h24,   32'h20,   32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[12] = '{1'b0, 2'b11, 2'b00, 32'h24,   32'h20,   32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b00, 2'b01, 32'h55667788, 32'h0};
    tv[13] = '{1'b0, 2'b10, 2'b10, 32'h0,    32'h0,    32'h0,        32'hCAFEF00D, 4'h0, 4'hF, 2'b10, 2'b00, 2'b10, 32'h0,        32'h11223344};
    tv[14] = '{1'b0, 2'b01, 2'b00, 32'h1000, 32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 2'b00, 32'h0,        32'h0};
    tv[15] = '{1'b0, 2'b01, 2'b01, 32'h1000, 32'h0,    32'hFFFFFFFF, 32'h0,        4'hF, 4'h0, 2'b01, 2'b01, 2'b01, 32'h0,        32'h0};
    tv[16] = '{1'b0, 2'b01, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[17] = '{1'b0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b01, 32'hCAFEF00D, 32'h0};
    tv[18] = '{1'b0, 2'b01, 2'b00, 32'h10,   32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[19] = '{1'b1, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[20] = '{1'b0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[21] = '{1'b0, 2'b11, 2'b00, 32'h10,   32'h24,   32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
    tv[22] = '{1'b0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b01, 32'hDEADBEAA, 32'h0};

    rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0; be = '0;
    s_rst = 1'b1; s_req = '0; s_wr = '0; s_addr = '0; s_wdata = '0; s_be = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst   = tv[i].rst;
      req   = tv[i].req;
      wr    = tv[i].wr;
      addr  = {tv[i].a1, tv[i].a0};
      wdata = {tv[i].d1, tv[i].d0};
      be    = {tv[i].be1, tv[i].be0};
      #2;
      chk("gnt",    i, 32'(gnt),      32'(tv[i].gnt));
      chk("err",    i, 32'(err),      32'(tv[i].err));
      chk("rvalid", i, 32'(rv),       32'(tv[i].rv));
      chk("rdata0", i, rdata[31:0],   tv[i].r0);
      chk("rdata1", i, rdata[63:32],  tv[i].r1);
    end

    // Fill words 0..3, then four back-to-back reads on both latency builds.
    repeat (2) @(negedge clk);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      s_rst = 1'b0; s_req = '0; s_wr = '0; s_addr = '0; s_wdata = '0; s_be = '0;
      if (c < 4) begin
        s_req = 2'b01; s_wr = 2'b01; s_addr[31:0] = 32'(c * 4);
        s_wdata[31:0] = 32'hA0A00000 + 32'(c); s_be[3:0] = 4'hF;
      end else if (c < 8) begin
        s_req = 2'b01; s_addr[31:0] = 32'((c - 4) * 4);
      end
      #2;
      chk("l3_rvalid", c, 32'(l3_rv), (c >= 7 && c <= 10) ? 32'd1 : 32'd0);
      chk("l3_rdata",  c, l3_rd[31:0], (c >= 7 && c <= 10) ? 32'hA0A00000 + 32'(c - 7) : 32'h0);
      chk("l2_rvalid", c, 32'(l2_rv), (c >= 6 && c <= 9) ? 32'd1 : 32'd0);
      chk("l2_rdata",  c, l2_rd[31:0], (c >= 6 && c <= 9) ? 32'hA0A00000 + 32'(c - 6) : 32'h0);
    end

    // Reset one cycle after a read grant: the read is dropped, storage survives.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      s_rst = (c == 1); s_req = '0; s_wr = '0; s_addr = '0; s_wdata = '0; s_be = '0;
      if (c == 0 || c == 7) begin
        s_req = 2'b10; s_addr[63:32] = 32'h4;
      end
      #2;
      if (c == 0) chk("l2_gnt", c, 32'(l2_gnt), 32'd2);
      chk("l2_rst_rvalid", c, 32'(l2_rv), (c == 9) ? 32'd2 : 32'd0);
      chk("l2_rst_rdata",  c, l2_rd[63:32], (c == 9) ? 32'hA0A00001 : 32'h0);
      chk("l3_rst_rvalid", c, 32'(l3_rv), (c == 10) ? 32'd2 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
